decode_phase_hazard_ctrl: RTL and testbench

//  Scoreboard and scheduler for the decode-phase operand path. Tracks in-flight register writers

---
 rtl/decode_phase_hazard_ctrl_if.sv | 35 +++
 rtl/decode_phase_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_decode_phase_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_phase_hazard_ctrl_if.sv
// Decode-slot operand/writer description in, stall and per-operand forward selects out.
// master drives the decode side; slave is the hazard controller.
interface decode_phase_hazard_ctrl_if #(
  parameter int POST_DEC_LD = 3,
  parameter int REG_IDX_W   = 5,
  parameter int LAT_W       = 2
);
  logic                   dec_valid;
  logic [REG_IDX_W-1:0]   dec_d_idx;
  logic [REG_IDX_W-1:0]   dec_s_idx;
  logic [REG_IDX_W-1:0]   dec_t_idx;
  logic [2:0]             dec_use_dst;
  logic                   dec_wr_en;
  logic [REG_IDX_W-1:0]   dec_wr_idx;
  logic [LAT_W-1:0]       dec_wr_lat;
  logic                   ext_stall;
  logic                   flush;
  logic                   stall;
  logic [POST_DEC_LD-1:0] fwd_d;
  logic [POST_DEC_LD-1:0] fwd_s;
  logic [POST_DEC_LD-1:0] fwd_t;
  logic [31:0]            stall_cnt;

  modport master (
    output dec_valid, dec_d_idx, dec_s_idx, dec_t_idx, dec_use_dst,
    output dec_wr_en, dec_wr_idx, dec_wr_lat, ext_stall, flush,
    input  stall, fwd_d, fwd_s, fwd_t, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_d_idx, dec_s_idx, dec_t_idx, dec_use_dst,
    input  dec_wr_en, dec_wr_idx, dec_wr_lat, ext_stall, flush,
    output stall, fwd_d, fwd_s, fwd_t, stall_cnt
  );
endinterface

// File: rtl/decode_phase_hazard_ctrl.sv
// In-flight writer scoreboard for the post-decode stages: picks the youngest producer per
// read operand, forwards it when its result is ready, otherwise stalls decode.
module decode_phase_hazard_ctrl #(
  parameter int POST_DEC_LD = 3,
  parameter int REG_IDX_W   = 5,
  parameter int RIP_IDX     = 16,
  parameter int LAT_W       = 2
) (
  input logic                  clk,
  input logic                  rstn,
  decode_phase_hazard_ctrl_if.slave bus
);
  localparam int NOPS = 3;
  localparam logic [REG_IDX_W-1:0] RIP = REG_IDX_W'(RIP_IDX);

  typedef struct packed {
    logic                 vld;
    logic [REG_IDX_W-1:0] idx;
    logic [LAT_W-1:0]     rem;
  } entry_t;

  entry_t                 entry_reg [POST_DEC_LD];
  entry_t                 entry_next;
  logic [31:0]            stall_cnt_reg;
  logic [REG_IDX_W-1:0]   op_idx [NOPS];
  logic [NOPS-1:0]        op_use;
  logic [NOPS-1:0]        op_haz;
  logic [POST_DEC_LD-1:0] op_fwd [NOPS];
  logic                   haz;
  logic                   live_haz;

  // Operand order 0/1/2 = d/s/t; dec_use_dst is packed {d,s,t}.
  assign op_idx[0] = bus.dec_d_idx;
  assign op_idx[1] = bus.dec_s_idx;
  assign op_idx[2] = bus.dec_t_idx;
  assign op_use    = {bus.dec_use_dst[0], bus.dec_use_dst[1], bus.dec_use_dst[2]};

  for (genvar gi = 0; gi < NOPS; gi++) begin : g_op
    logic [POST_DEC_LD-1:0] match;
    logic [POST_DEC_LD-1:0] fwd_sel;
    logic                   pend;

    always_comb begin
      match   = '0;
      fwd_sel = '0;
      pend    = 1'b0;
      for (int k = 0; k < POST_DEC_LD; k++) begin
        match[k] = op_use[gi] & entry_reg[k].vld & (entry_reg[k].idx == op_idx[gi])
                   & (op_idx[gi] != RIP);
      end
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int k = POST_DEC_LD - 1; k >= 0; k--) begin
        if (match[k]) begin
          fwd_sel = '0;
          pend    = 1'b0;
          if (entry_reg[k].rem == '0) fwd_sel[k] = 1'b1;
          else                        pend       = 1'b1;
        end
      end
    end

    assign op_fwd[gi] = fwd_sel;
    assign op_haz[gi] = pend;
  end

  assign haz      = bus.dec_valid & (|op_haz);
  // A flushed instruction is dead, so its hazard neither stalls nor counts.
  assign live_haz = haz & ~bus.flush;

  always_comb begin
    entry_next.vld = bus.dec_valid & bus.dec_wr_en & ~haz & ~bus.flush & (bus.dec_wr_idx != RIP);
    entry_next.idx = bus.dec_wr_idx;
    entry_next.rem = bus.dec_wr_lat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < POST_DEC_LD; k++) entry_reg[k] <= '0;
      stall_cnt_reg <= '0;
    end else if (!bus.ext_stall) begin
      entry_reg[0] <= entry_next;
      for (int k = 1; k < POST_DEC_LD; k++) begin
        entry_reg[k].vld <= entry_reg[k-1].vld;
        entry_reg[k].idx <= entry_reg[k-1].idx;
        entry_reg[k].rem <= (entry_reg[k-1].rem == '0) ? '0 : entry_reg[k-1].rem - LAT_W'(1);
      end
      if (live_haz) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  // Outputs are forced low while reset is held, including the ext_stall pass-through.
  assign bus.stall     = rstn & (live_haz | bus.ext_stall);
  assign bus.fwd_d     = rstn ? op_fwd[0] : '0;
  assign bus.fwd_s     = rstn ? op_fwd[1] : '0;
  assign bus.fwd_t     = rstn ? op_fwd[2] : '0;
  assign bus.stall_cnt = stall_cnt_reg;

  a_wr_lat_legal: assert property (@(posedge clk) disable iff (!rstn)
    (bus.dec_valid & bus.dec_wr_en) |-> (int'(bus.dec_wr_lat) < POST_DEC_LD));

endmodule

// File: tb/tb_decode_phase_hazard_ctrl.sv
// Directed vector table, hand sequences for stall/flush/reset corners, then random
// traffic checked against a producer-age model of the scoreboard.
module tb_decode_phase_hazard_ctrl;
  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  decode_phase_hazard_ctrl_if bus_if ();

  decode_phase_hazard_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: list of producers, youngest first ----------------
  typedef struct {
    logic [4:0] idx;
    int         lat;
    int         age;
  } prod_t;

  prod_t      q[$];
  logic [31:0] m_cnt;
  logic       m_haz;
  logic       m_stall;
  logic [2:0] m_fwd [3];

  function automatic void model_eval();
    logic [4:0] ix [3];
    logic       ux [3];
    logic       pend;
    ix[0] = bus_if.dec_d_idx; ix[1] = bus_if.dec_s_idx; ix[2] = bus_if.dec_t_idx;
    ux[0] = bus_if.dec_use_dst[2]; ux[1] = bus_if.dec_use_dst[1]; ux[2] = bus_if.dec_use_dst[0];
    pend = 1'b0;
    for (int x = 0; x < 3; x++) begin
      logic found;
      m_fwd[x] = 3'b000;
      found = 1'b0;
      if (ux[x] && ix[x] != 5'd16) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!found && q[i].idx == ix[x]) begin
            found = 1'b1;
            if (q[i].age >= q[i].lat) m_fwd[x][q[i].age] = 1'b1;
            else pend = 1'b1;
          end
        end
      end
    end
    m_haz   = bus_if.dec_valid & pend & ~bus_if.flush;
    m_stall = m_haz | bus_if.ext_stall;
  endfunction

  function automatic void model_step();
    prod_t p;
    if (!bus_if.ext_stall) begin
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      while (q.size() > 0 && q[q.size()-1].age >= 3) void'(q.pop_back());
      if (bus_if.dec_valid && bus_if.dec_wr_en && !m_haz && !bus_if.flush
          && bus_if.dec_wr_idx != 5'd16) begin
        p.idx = bus_if.dec_wr_idx;
        p.lat = int'(bus_if.dec_wr_lat);
        p.age = 0;
        q.push_front(p);
      end
      if (m_haz) m_cnt = m_cnt + 32'd1;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic es, input logic [2:0] efd,
                            input logic [2:0] efs, input logic [2:0] eft, input logic [31:0] ecnt);
    chk({tag, ".stall"}, 32'(bus_if.stall), 32'(es));
    chk({tag, ".fwd_d"}, 32'(bus_if.fwd_d), 32'(efd));
    chk({tag, ".fwd_s"}, 32'(bus_if.fwd_s), 32'(efs));
    chk({tag, ".fwd_t"}, 32'(bus_if.fwd_t), 32'(eft));
    chk({tag, ".stall_cnt"}, bus_if.stall_cnt, ecnt);
    $display("%s: stall=%0b fwd_d=%b fwd_s=%b fwd_t=%b stall_cnt=%0d",
             tag, bus_if.stall, bus_if.fwd_d, bus_if.fwd_s, bus_if.fwd_t, bus_if.stall_cnt);
  endtask

  task automatic set_in(input logic v, input logic [4:0] d, input logic [4:0] s,
                        input logic [4:0] t, input logic [2:0] u, input logic we,
                        input logic [4:0] wi, input logic [1:0] wl, input logic ext,
                        input logic fl);
    bus_if.dec_valid   = v;
    bus_if.dec_d_idx   = d;
    bus_if.dec_s_idx   = s;
    bus_if.dec_t_idx   = t;
    bus_if.dec_use_dst = u;
    bus_if.dec_wr_en   = we;
    bus_if.dec_wr_idx  = wi;
    bus_if.dec_wr_lat  = wl;
    bus_if.ext_stall   = ext;
    bus_if.flush       = fl;
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] d, s, t;
    logic [2:0] u;
    logic       we;
    logic [4:0] wi;
    logic [1:0] wl;
    logic       es;
    logic [2:0] efd, efs, eft;
    logic [31:0] ecnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] d, logic [4:0] s, logic [4:0] t,
                              logic [2:0] u, logic we, logic [4:0] wi, logic [1:0] wl,
                              logic es, logic [2:0] efd, logic [2:0] efs, logic [2:0] eft,
                              logic [31:0] ecnt);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.t = t; r.u = u; r.we = we; r.wi = wi; r.wl = wl;
    r.es = es; r.efd = efd; r.efs = efs; r.eft = eft; r.ecnt = ecnt;
    return r;
  endfunction

  vec_t tbl [17];
  logic [4:0] pool [4];

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_cnt   = '0;
    pool[0] = 5'd1; pool[1] = 5'd2; pool[2] = 5'd3; pool[3] = 5'd16;

    //            v  d   s   t   u      we wi  wl  es efd    efs    eft    cnt
    tbl[0]  = mk(1, 0,  0,  0,  3'b000, 1, 3,  1,  0, 3'b000,3'b000,3'b000, 0); // load r3, lat 1
    tbl[1]  = mk(1, 0,  3,  0,  3'b010, 1, 4,  0,  1, 3'b000,3'b000,3'b000, 0); // load-use stall
    tbl[2]  = mk(1, 0,  3,  0,  3'b010, 1, 4,  0,  0, 3'b000,3'b010,3'b000, 1); // resolved via stage 1
    tbl[3]  = mk(1, 0,  0,  0,  3'b000, 1, 1,  0,  0, 3'b000,3'b000,3'b000, 1); // r1 <= alu
    tbl[4]  = mk(1, 1,  0,  0,  3'b100, 0, 0,  0,  0, 3'b001,3'b000,3'b000, 1);
    tbl[5]  = mk(1, 1,  0,  0,  3'b100, 0, 0,  0,  0, 3'b010,3'b000,3'b000, 1);
    tbl[6]  = mk(1, 0,  0,  0,  3'b000, 1, 2,  0,  0, 3'b000,3'b000,3'b000, 1); // r2 (older)
    tbl[7]  = mk(1, 0,  0,  0,  3'b000, 1, 9,  0,  0, 3'b000,3'b000,3'b000, 1);
    tbl[8]  = mk(1, 0,  0,  0,  3'b000, 1, 2,  0,  0, 3'b000,3'b000,3'b000, 1); // r2 (younger)
    tbl[9]  = mk(1, 0,  0,  2,  3'b001, 0, 0,  0,  0, 3'b000,3'b000,3'b001, 1); // youngest wins
    tbl[10] = mk(1, 0,  0,  0,  3'b000, 1, 2,  0,  0, 3'b000,3'b000,3'b000, 1);
    tbl[11] = mk(1, 0,  0,  0,  3'b000, 1, 7,  0,  0, 3'b000,3'b000,3'b000, 1);
    tbl[12] = mk(1, 0,  0,  0,  3'b000, 1, 2,  1,  0, 3'b000,3'b000,3'b000, 1); // young r2 lat 1
    tbl[13] = mk(1, 0,  0,  2,  3'b001, 0, 0,  0,  1, 3'b000,3'b000,3'b000, 1); // stall despite ready stage 2
    tbl[14] = mk(1, 0,  0,  2,  3'b001, 0, 0,  0,  0, 3'b000,3'b000,3'b010, 2);
    tbl[15] = mk(1, 16, 16, 0,  3'b110, 1, 16, 0,  0, 3'b000,3'b000,3'b000, 2); // RIP write+read
    tbl[16] = mk(1, 0,  16, 0,  3'b010, 0, 0,  0,  0, 3'b000,3'b000,3'b000, 2);

    // Reset state, with ext_stall high to show outputs are held low.
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
    #12;
    check_outs("reset", 0, 3'b000, 3'b000, 3'b000, 0);
    bus_if.ext_stall = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].t, tbl[i].u, tbl[i].we, tbl[i].wi,
             tbl[i].wl, 0, 0);
      #2;
      check_outs($sformatf("vec%0d", i), tbl[i].es, tbl[i].efd, tbl[i].efs, tbl[i].eft,
                 tbl[i].ecnt);
      advance();
    end

    // ext_stall freezes a pending load for three cycles.
    set_in(1, 0, 0, 0, 3'b000, 1, 3, 1, 0, 0);
    #2; check_outs("ext.load", 0, 3'b000, 3'b000, 3'b000, 2);
    advance();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 3, 0, 3'b010, 0, 0, 0, 1, 0);
      #2; check_outs($sformatf("ext.hold%0d", i), 1, 3'b000, 3'b000, 3'b000, 2);
      advance();
    end
    set_in(1, 0, 3, 0, 3'b010, 0, 0, 0, 0, 0);
    #2; check_outs("ext.release", 1, 3'b000, 3'b000, 3'b000, 2);
    advance();
    #2; check_outs("ext.resolved", 0, 3'b000, 3'b010, 3'b000, 3);
    advance();

    // flush coincident with a hazard: no stall, no count, killed writer not inserted.
    set_in(1, 0, 0, 0, 3'b000, 1, 5, 1, 0, 0);
    #2; check_outs("flush.load", 0, 3'b000, 3'b000, 3'b000, 3);
    advance();
    set_in(1, 5, 0, 0, 3'b100, 1, 6, 0, 0, 1);
    #2; check_outs("flush.haz", 0, 3'b000, 3'b000, 3'b000, 3);
    advance();
    set_in(1, 5, 0, 6, 3'b101, 0, 0, 0, 0, 0);
    #2; check_outs("flush.after", 0, 3'b010, 3'b000, 3'b000, 3);
    advance();

    // Asynchronous reset in the middle of a stall.
    set_in(1, 0, 0, 0, 3'b000, 1, 8, 2, 0, 0);
    #2; check_outs("rst.load", 0, 3'b000, 3'b000, 3'b000, 3);
    advance();
    set_in(1, 0, 8, 0, 3'b010, 0, 0, 0, 0, 0);
    #2; check_outs("rst.pre", 1, 3'b000, 3'b000, 3'b000, 3);
    rstn = 1'b0;
    #1; check_outs("rst.mid", 0, 3'b000, 3'b000, 3'b000, 0);
    q.delete();
    m_cnt = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #2; check_outs("rst.after", 0, 3'b000, 3'b000, 3'b000, 0);
    advance();

    // Random traffic against the model.
    for (int c = 0; c < 250; c++) begin
      set_in($urandom_range(0, 9) < 8,
             pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
             2'($urandom_range(0, 2)), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      #2;
      model_eval();
      check_outs($sformatf("rnd%0d", c), m_stall, m_fwd[0], m_fwd[1], m_fwd[2], m_cnt);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
